keypad_scanner: RTL and testbench

- Input-side counterpart to the 7-segment display interface: scans a 4x4 hex keypad (Pmod KYPD style) by driving one active-low column at a time and reading active-low rows.
- Debounces the result over whole scans and emits a 4-bit hex key code with a one-cycle valid pulse plus a held level.
- Outputs feed the stopwatch control logic (value entry / commands) and the display value path.

---
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad one column at a time and debounces
// over whole scans, giving the accepted key code, a one-cycle valid pulse and a held level.
module keypad_scanner #(
  parameter int unsigned SCAN_BITS      = 11,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key,
  output logic       keyValid,
  output logic       keyHeld
);
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;

  logic [3:0]           row_s1_q, row_s2_q;
  logic [SCAN_BITS-1:0] presc_q;
  logic [1:0]           col_q, col_d;
  logic [3:0]           column_q;
  logic [1:0]           acc_cnt_q, acc_cnt_d;
  logic [3:0]           first_q, first_d;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d, cand_q, cand_d, key_q, key_d;
  logic                 valid_q, valid_d, held_q, held_d;

  logic       tick, eos;
  logic [3:0] pressed;
  logic [2:0] samp_cnt, total;
  logic [1:0] low_r;
  logic [3:0] samp_key, scan_key, cnt_inc;
  res_t       res;
  logic       cnt_done, cand_match;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan datapath: the sample taken on the last column's tick is folded into the result.
  always_comb begin
    tick     = &presc_q;
    eos      = tick && (col_q == 2'd3);
    col_d    = tick ? col_q + 2'd1 : col_q;
    pressed  = ~row_s2_q;
    samp_cnt = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
    if (pressed[0])      low_r = 2'd0;
    else if (pressed[1]) low_r = 2'd1;
    else if (pressed[2]) low_r = 2'd2;
    else                 low_r = 2'd3;
    samp_key = key_code(low_r, col_q);
    total    = 3'(acc_cnt_q) + samp_cnt;
    scan_key = (acc_cnt_q == 2'd0) ? samp_key : first_q;
    if (total == 3'd0)      res = RES_NONE;
    else if (total == 3'd1) res = RES_KEY;
    else                    res = RES_MULTI;
    acc_cnt_d = acc_cnt_q;
    first_d   = first_q;
    if (eos) begin
      acc_cnt_d = '0;
      first_d   = '0;
    end else if (tick) begin
      acc_cnt_d = (total >= 3'd2) ? 2'd2 : total[1:0];
      if (acc_cnt_q == 2'd0 && samp_cnt != 3'd0) first_d = samp_key;
    end
    cnt_inc    = cnt_q + 4'd1;
    cnt_done   = (cnt_inc == 4'(DEBOUNCE_SCANS));
    cand_match = (res == RES_KEY) && (scan_key == cand_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      presc_q   <= '0;
      col_q     <= '0;
      column_q  <= 4'b1110;
      acc_cnt_q <= '0;
      first_q   <= '0;
      cnt_q     <= '0;
      cand_q    <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      presc_q   <= presc_q + SCAN_BITS'(1);
      col_q     <= col_d;
      column_q  <= ~(4'b0001 << col_d);
      acc_cnt_q <= acc_cnt_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (eos) begin
      case (state_q)
        ST_IDLE:     if (res == RES_KEY) state_d = ST_DEBOUNCE;
        ST_DEBOUNCE: if (!cand_match) state_d = ST_IDLE;
                     else if (cnt_done) state_d = ST_PRESSED;
        ST_PRESSED:  if (res == RES_NONE) state_d = ST_RELEASE;
        ST_RELEASE:  if (res != RES_NONE) state_d = ST_PRESSED;
                     else if (cnt_done) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (eos) begin
      case (state_q)
        ST_IDLE: if (res == RES_KEY) begin
          cand_d = scan_key;
          cnt_d  = 4'd1;
        end
        ST_DEBOUNCE: begin
          if (!cand_match) cnt_d = '0;
          else begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              key_d   = cand_q;
              held_d  = 1'b1;
              valid_d = 1'b1;
            end
          end
        end
        ST_PRESSED: if (res == RES_NONE) cnt_d = 4'd1;
        ST_RELEASE: begin
          if (res == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              cnt_d  = '0;
              held_d = 1'b0;
            end
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign column   = column_q;
  assign key      = key_q;
  assign keyValid = valid_q;
  assign keyHeld  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driven by a pressed-key mask, table of scan-aligned
// steps with expected pulse count / key / held, plus column-sequence and async-reset sequences.
module tb_keypad_scanner;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] column, key;
  logic       keyValid, keyHeld;
  logic [15:0] keys = '0;  // bit r*4+c = key at row r, column c pressed

  int errors = 0;
  int checks = 0;

  keypad_scanner #(.SCAN_BITS(2), .DEBOUNCE_SCANS(4)) dut (
    .clock(clock), .reset(reset), .row(row), .column(column),
    .key(key), .keyValid(keyValid), .keyHeld(keyHeld)
  );

  always #5 clock = ~clock;

  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      if (!column[c])
        for (int r = 0; r < 4; r++)
          if (keys[r*4+c]) row[r] = 1'b0;
  end

  localparam logic [15:0] K1 = 16'h0001, K5 = 16'h0020, K8 = 16'h0200,
                          KA = 16'h0008, KD = 16'h8000, KF = 16'h2000;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          scans;
    int          pulses;
    logic [3:0]  key;
    logic        held;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Starts and ends at a negedge; scan boundaries stay aligned to reset release.
  task automatic run_scans(input int n, output int pulses);
    pulses = 0;
    repeat (n * 16) begin
      @(posedge clock);
      @(negedge clock);
      if (keyValid === 1'b1) pulses++;
    end
  endtask

  task automatic add(input string name, input logic [15:0] k, input int s, input int p,
                     input logic [3:0] ek, input logic eh);
    vec_t v;
    v.name = name; v.keys = k; v.scans = s; v.pulses = p; v.key = ek; v.held = eh;
    vecs.push_back(v);
  endtask

  initial begin
    int p;
    logic [3:0] exp_col;
    add("idle",          '0,      1, 0, 4'h0, 1'b0);
    add("k8_debounce",   K8,      3, 0, 4'h0, 1'b0);
    add("k8_accept",     K8,      1, 1, 4'h8, 1'b1);
    add("k8_hold",       K8,      3, 0, 4'h8, 1'b1);
    add("k8_rel_wait",   '0,      3, 0, 4'h8, 1'b1);
    add("k8_released",   '0,      1, 0, 4'h8, 1'b0);
    add("a_bounce_on",   KA,      2, 0, 4'h8, 1'b0);
    add("a_gap",         '0,      1, 0, 4'h8, 1'b0);
    add("a_debounce",    KA,      3, 0, 4'h8, 1'b0);
    add("a_accept",      KA,      1, 1, 4'hA, 1'b1);
    add("a_release",     '0,      4, 0, 4'hA, 1'b0);
    add("k5_accept",     K5,      4, 1, 4'h5, 1'b1);
    add("k5_other_key",  KD,      4, 0, 4'h5, 1'b1);
    add("k5_short_rel",  '0,      2, 0, 4'h5, 1'b1);
    add("k5_repress",    K5,      2, 0, 4'h5, 1'b1);
    add("k5_release",    '0,      4, 0, 4'h5, 1'b0);
    add("d_accept",      KD,      4, 1, 4'hD, 1'b1);
    add("d_release",     '0,      4, 0, 4'hD, 1'b0);
    add("multi",         K1 | KF, 3, 0, 4'hD, 1'b0);
    add("one_debounce",  K1,      3, 0, 4'hD, 1'b0);
    add("one_accept",    K1,      1, 1, 4'h1, 1'b1);
    add("one_release",   '0,      4, 0, 4'h1, 1'b0);

    repeat (2) @(negedge clock);
    check("rst_column", 32'(column), 32'h0000000E);
    check("rst_key",    32'(key),    32'h0);
    check("rst_valid",  32'(keyValid), 32'h0);
    check("rst_held",   32'(keyHeld),  32'h0);
    reset = 1'b1;

    // First scan: each column value lasts exactly 4 cycles.
    p = 0;
    for (int unsigned i = 1; i <= 16; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (keyValid === 1'b1) p++;
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("column_cyc%0d", i), 32'(column), 32'(exp_col));
    end
    check("scan0_pulses", p, 0);

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      run_scans(vecs[i].scans, p);
      check({vecs[i].name, "_pulses"}, p, vecs[i].pulses);
      check({vecs[i].name, "_key"},    32'(key),     32'(vecs[i].key));
      check({vecs[i].name, "_held"},   32'(keyHeld), 32'(vecs[i].held));
    end

    // Async reset mid-DEBOUNCE (cnt=3), asserted between edges.
    keys = K8;
    run_scans(3, p);
    check("pre_rst_pulses", p, 0);
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("pre_rst_column", 32'(column), 32'h0000000D);
    #2 reset = 1'b0;
    #1;
    check("async_column", 32'(column),   32'h0000000E);
    check("async_key",    32'(key),      32'h0);
    check("async_valid",  32'(keyValid), 32'h0);
    check("async_held",   32'(keyHeld),  32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    run_scans(3, p);
    check("restart_pulses", p, 0);
    check("restart_held", 32'(keyHeld), 32'h0);
    run_scans(1, p);
    check("restart_accept_pulses", p, 1);
    check("restart_accept_key",  32'(key),     32'h8);
    check("restart_accept_held", 32'(keyHeld), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
